// File: rtl/mc_bus_initiator_if.sv
// Request/response and memory-controller bus signals of the bus initiator.
// Handshake: a request transfers on a rising clock edge where req_valid && req_ready;
// req_* must be stable while req_valid is high; rsp_valid is a one-cycle pulse with no back-pressure.
interface mc_bus_initiator_if #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [MC_ADD_WIDTH-1:0]  req_add;
  logic [MC_DATA_WIDTH-1:0] req_wdata;
  logic                     rsp_valid;
  logic [MC_DATA_WIDTH-1:0] rsp_rdata;
  logic                     busy;
  logic                     mc_ce;
  logic                     mc_we;
  logic                     mc_oe;
  logic [MC_ADD_WIDTH-1:0]  mc_add;
  logic [MC_DATA_WIDTH-1:0] mc_dout;
  logic                     mc_doe;
  logic [MC_DATA_WIDTH-1:0] mc_din;
  logic [2:0]               fsm_state;

  modport master (
    input  req_valid, req_write, req_add, req_wdata, mc_din,
    output req_ready, rsp_valid, rsp_rdata, busy,
           mc_ce, mc_we, mc_oe, mc_add, mc_dout, mc_doe, fsm_state
  );

  modport slave (
    output req_valid, req_write, req_add, req_wdata, mc_din,
    input  req_ready, rsp_valid, rsp_rdata, busy,
           mc_ce, mc_we, mc_oe, mc_add, mc_dout, mc_doe, fsm_state
  );
endinterface

// File: rtl/mc_bus_initiator.sv
// Memory-controller bus initiator: turns single read/write requests into timed
// async-SRAM style cycles (setup / strobe / hold / read turnaround). All bus outputs registered.
module mc_bus_initiator #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2,
  parameter int TURN_CYCLES   = 1
) (
  input  logic               clock,
  input  logic               reset,
  mc_bus_initiator_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    TURN   = 3'd4
  } state_t;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] TURN_LD   = 8'(TURN_CYCLES - 1);

  state_t                   state, state_n;
  logic [7:0]               cnt, cnt_n;
  logic                     wr_q, wr_n;
  logic [MC_ADD_WIDTH-1:0]  add_q, add_n;
  logic [MC_DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic                     capture;

  logic                     on_bus, strobe_n;
  logic                     ready_n, busy_n, ce_n, we_n, oe_n, doe_n;
  logic [MC_DATA_WIDTH-1:0] dout_n;

  logic                     ready_q, busy_q, ce_q, we_q, oe_q, doe_q, rsp_valid_q;
  logic [MC_DATA_WIDTH-1:0] dout_q, rdata_q;

  // Next state plus the bus levels that state implies; both are registered together.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wr_n    = wr_q;
    add_n   = add_q;
    wdata_n = wdata_q;
    capture = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          state_n = SETUP;
          cnt_n   = SETUP_LD;
          wr_n    = bus.req_write;
          add_n   = bus.req_add;
          wdata_n = bus.req_wdata;
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          state_n = STROBE;
          cnt_n   = STROBE_LD;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      STROBE: begin
        if (cnt == 8'd0) begin
          state_n = HOLD;
          cnt_n   = HOLD_LD;
          // Read data sampled on the edge that ends the strobe, while OE is still low.
          capture = !wr_q;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      HOLD: begin
        if (cnt == 8'd0) begin
          state_n = wr_q ? IDLE : TURN;
          cnt_n   = wr_q ? 8'd0 : TURN_LD;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      TURN: begin
        if (cnt == 8'd0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end
    endcase

    on_bus   = (state_n == SETUP) || (state_n == STROBE) || (state_n == HOLD);
    strobe_n = (state_n == STROBE);
    ready_n  = (state_n == IDLE);
    busy_n   = (state_n != IDLE);
    ce_n     = !on_bus;
    we_n     = !(strobe_n && wr_n);
    oe_n     = !(strobe_n && !wr_n);
    doe_n    = on_bus && wr_n;
    dout_n   = doe_n ? wdata_n : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      wr_q        <= 1'b0;
      add_q       <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      ce_q        <= 1'b1;
      we_q        <= 1'b1;
      oe_q        <= 1'b1;
      doe_q       <= 1'b0;
      dout_q      <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      wr_q        <= wr_n;
      add_q       <= add_n;
      wdata_q     <= wdata_n;
      ready_q     <= ready_n;
      busy_q      <= busy_n;
      ce_q        <= ce_n;
      we_q        <= we_n;
      oe_q        <= oe_n;
      doe_q       <= doe_n;
      dout_q      <= dout_n;
      rsp_valid_q <= capture;
      if (capture) begin
        rdata_q <= bus.mc_din;
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.mc_ce     = ce_q;
  assign bus.mc_we     = we_q;
  assign bus.mc_oe     = oe_q;
  assign bus.mc_add    = add_q;
  assign bus.mc_dout   = dout_q;
  assign bus.mc_doe    = doe_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_mc_bus_initiator.sv
// Bench for mc_bus_initiator: default-timing and all-ones-timing instances, each with a
// small SRAM-like responder; expected waveforms derived from cycle index arithmetic.
module tb_mc_bus_initiator;

  logic clock = 1'b0;
  logic reset_a;
  logic reset_b;
  logic mem_init;

  always #5 clock = ~clock;

  mc_bus_initiator_if #(.MC_DATA_WIDTH(16), .MC_ADD_WIDTH(6)) ifa ();
  mc_bus_initiator_if #(.MC_DATA_WIDTH(16), .MC_ADD_WIDTH(6)) ifb ();

  mc_bus_initiator #(
    .MC_DATA_WIDTH(16), .MC_ADD_WIDTH(6),
    .SETUP_CYCLES(2), .STROBE_CYCLES(4), .HOLD_CYCLES(2), .TURN_CYCLES(1)
  ) dut_a (
    .clock (clock),
    .reset (reset_a),
    .bus   (ifa.master)
  );

  mc_bus_initiator #(
    .MC_DATA_WIDTH(16), .MC_ADD_WIDTH(6),
    .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1), .TURN_CYCLES(1)
  ) dut_b (
    .clock (clock),
    .reset (reset_b),
    .bus   (ifb.master)
  );

  // Responders: drive stored data while OE is low, store pad data while WE is low.
  logic [15:0] resp_mem_a [64];
  logic [15:0] resp_mem_b [64];

  always_comb ifa.mc_din = ifa.mc_oe ? 16'h0BAD : resp_mem_a[ifa.mc_add];
  always_comb ifb.mc_din = ifb.mc_oe ? 16'h0BAD : resp_mem_b[ifb.mc_add];

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) resp_mem_a[i] <= 16'h1234 + 16'(i) - 16'd26;
    end else if (!ifa.mc_we) begin
      resp_mem_a[ifa.mc_add] <= ifa.mc_dout;
    end
  end

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) resp_mem_b[i] <= 16'h1234 + 16'(i) - 16'd26;
    end else if (!ifb.mc_we) begin
      resp_mem_b[ifb.mc_add] <= ifb.mc_dout;
    end
  end

  // Reference model state
  logic [15:0] exp_mem [2][64];
  logic [15:0] last_rd [2];
  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        ce;
    logic        we;
    logic        oe;
    logic        doe;
    logic        rv;
    logic [5:0]  add;
    logic [15:0] dout;
    logic [15:0] rdata;
  } obs_t;

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    if (sel == 0) begin
      o = '{ifa.req_ready, ifa.busy, ifa.mc_ce, ifa.mc_we, ifa.mc_oe, ifa.mc_doe,
            ifa.rsp_valid, ifa.mc_add, ifa.mc_dout, ifa.rsp_rdata};
    end else begin
      o = '{ifb.req_ready, ifb.busy, ifb.mc_ce, ifb.mc_we, ifb.mc_oe, ifb.mc_doe,
            ifb.rsp_valid, ifb.mc_add, ifb.mc_dout, ifb.rsp_rdata};
    end
    return o;
  endfunction

  task automatic get_timing(input int sel, output int s, output int t, output int h, output int u);
    if (sel == 0) begin s = 2; t = 4; h = 2; u = 1; end
    else          begin s = 1; t = 1; h = 1; u = 1; end
  endtask

  task automatic set_req(input int sel, input logic v, input logic w,
                         input logic [5:0] a, input logic [15:0] d);
    if (sel == 0) begin
      ifa.req_valid = v; ifa.req_write = w; ifa.req_add = a; ifa.req_wdata = d;
    end else begin
      ifb.req_valid = v; ifb.req_write = w; ifb.req_add = a; ifb.req_wdata = d;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset(input int sel);
    obs_t o;
    o = get_obs(sel);
    check("rst_ce", 32'(o.ce), 32'd1);
    check("rst_we", 32'(o.we), 32'd1);
    check("rst_oe", 32'(o.oe), 32'd1);
    check("rst_doe", 32'(o.doe), 32'd0);
    check("rst_add", 32'(o.add), 32'd0);
    check("rst_dout", 32'(o.dout), 32'd0);
    check("rst_rv", 32'(o.rv), 32'd0);
    check("rst_rdata", 32'(o.rdata), 32'd0);
    check("rst_ready", 32'(o.ready), 32'd1);
    check("rst_busy", 32'(o.busy), 32'd0);
  endtask

  // Expected bus levels in cycle k (1 = first cycle after the accepting edge).
  task automatic check_cycle(input int sel, input logic wr, input logic [5:0] a,
                             input logic [15:0] d, input int k, input logic [15:0] exp_rd);
    int s, t, h, u;
    bit on, str;
    obs_t o;
    get_timing(sel, s, t, h, u);
    o   = get_obs(sel);
    on  = (k <= s + t + h);
    str = (k > s) && (k <= s + t);
    check("cyc_ready", 32'(o.ready), 32'd0);
    check("cyc_busy", 32'(o.busy), 32'd1);
    check("cyc_ce", 32'(o.ce), 32'(!on));
    check("cyc_we", 32'(o.we), 32'(!(wr && str)));
    check("cyc_oe", 32'(o.oe), 32'(!(!wr && str)));
    check("cyc_doe", 32'(o.doe), 32'(wr && on));
    check("cyc_doe_vs_oe", 32'(o.doe && !o.oe), 32'd0);
    if (on) check("cyc_add", 32'(o.add), 32'(a));
    if (wr && on) check("cyc_dout", 32'(o.dout), 32'(d));
    check("cyc_rsp_valid", 32'(o.rv), 32'(!wr && (k == s + t + 1)));
    if (!wr && k > s + t) check("cyc_rdata", 32'(o.rdata), 32'(exp_rd));
    else                  check("cyc_rdata_hold", 32'(o.rdata), 32'(last_rd[sel]));
  endtask

  // Runs one transaction from a negedge where the DUT should be idle.
  task automatic run_txn(input int sel, input logic wr, input logic [5:0] a,
                         input logic [15:0] d, input bit noise, input bit keep);
    int s, t, h, u, total, guard;
    logic [15:0] exp_rd;
    obs_t o;
    get_timing(sel, s, t, h, u);
    total = s + t + h + (wr ? 0 : u);
    guard = 0;
    o = get_obs(sel);
    while (!o.ready && guard < 100) begin
      @(negedge clock);
      guard++;
      o = get_obs(sel);
    end
    check("idle_before_req", 32'(o.ready), 32'd1);
    check("ce_idle", 32'(o.ce), 32'd1);
    set_req(sel, 1'b1, wr, a, d);
    if (wr) begin
      exp_mem[sel][a] = d;
      exp_rd = last_rd[sel];
    end else begin
      exp_rd = exp_mem[sel][a];
    end
    @(negedge clock);
    for (int k = 1; k <= total; k++) begin
      check_cycle(sel, wr, a, d, k, exp_rd);
      if (!keep) begin
        if (noise) set_req(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           6'($urandom_range(0, 63)), 16'($urandom));
        else       set_req(sel, 1'b0, wr, a, d);
      end
      @(negedge clock);
    end
    if (!wr) last_rd[sel] = exp_rd;
    o = get_obs(sel);
    check("ready_back", 32'(o.ready), 32'd1);
    check("busy_clear", 32'(o.busy), 32'd0);
    check("ce_back", 32'(o.ce), 32'd1);
    check("rv_clear", 32'(o.rv), 32'd0);
    check("rdata_final", 32'(o.rdata), 32'(last_rd[sel]));
    if (!keep) set_req(sel, 1'b0, wr, a, d);
  endtask

  task automatic reset_mid_read(input logic [5:0] a);
    int s, t, h, u;
    logic [15:0] exp_rd;
    obs_t o;
    get_timing(0, s, t, h, u);
    exp_rd = exp_mem[0][a];
    set_req(0, 1'b1, 1'b0, a, 16'h0);
    @(negedge clock);
    set_req(0, 1'b0, 1'b0, a, 16'h0);
    for (int k = 1; k <= s + 2; k++) begin
      check_cycle(0, 1'b0, a, 16'h0, k, exp_rd);
      if (k < s + 2) @(negedge clock);
    end
    reset_a = 1'b1;
    @(negedge clock);
    reset_a = 1'b0;
    last_rd[0] = '0;
    check_reset(0);
    @(negedge clock);
    o = get_obs(0);
    check("rv_after_reset", 32'(o.rv), 32'd0);
    check("ce_after_reset", 32'(o.ce), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_a  = 1'b1;
    reset_b  = 1'b1;
    mem_init = 1'b1;
    set_req(0, 1'b0, 1'b0, 6'h0, 16'h0);
    set_req(1, 1'b0, 1'b0, 6'h0, 16'h0);
    for (int sl = 0; sl < 2; sl++) begin
      last_rd[sl] = '0;
      for (int i = 0; i < 64; i++) exp_mem[sl][i] = 16'h1234 + 16'(i) - 16'd26;
    end
    repeat (3) @(negedge clock);
    check_reset(0);
    check_reset(1);
    reset_a  = 1'b0;
    reset_b  = 1'b0;
    mem_init = 1'b0;
    @(negedge clock);

    // Default timing: directed write and read
    run_txn(0, 1'b1, 6'h19, 16'hBEEF, 1'b0, 1'b0);
    run_txn(0, 1'b0, 6'h1A, 16'h0000, 1'b0, 1'b0);
    // Back-to-back with req_valid held
    run_txn(0, 1'b1, 6'h05, 16'hA5A5, 1'b0, 1'b1);
    run_txn(0, 1'b0, 6'h05, 16'h0000, 1'b0, 1'b0);
    // Requests wiggling while busy
    run_txn(0, 1'b1, 6'h22, 16'h1111, 1'b1, 1'b0);
    run_txn(0, 1'b0, 6'h22, 16'h0000, 1'b1, 1'b0);
    // Reset during the second strobe cycle of a read, then a full read
    reset_mid_read(6'h19);
    run_txn(0, 1'b0, 6'h19, 16'h0000, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_txn(0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 16'($urandom),
              1'($urandom_range(0, 1)), (n != 39) && ($urandom_range(0, 3) == 0));
    end
    set_req(0, 1'b0, 1'b0, 6'h0, 16'h0);
    @(negedge clock);

    // Minimum timing instance
    run_txn(1, 1'b1, 6'h03, 16'hCAFE, 1'b0, 1'b0);
    run_txn(1, 1'b0, 6'h03, 16'h0000, 1'b0, 1'b0);
    run_txn(1, 1'b1, 6'h3F, 16'h0F0F, 1'b0, 1'b1);
    run_txn(1, 1'b0, 6'h3F, 16'h0000, 1'b0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      run_txn(1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 16'($urandom),
              1'($urandom_range(0, 1)), (n != 39) && ($urandom_range(0, 3) == 0));
    end
    set_req(1, 1'b0, 1'b0, 6'h0, 16'h0);
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
